// File: rtl/ov7670_sccb_init.sv
`default_nettype none
// ============================================================================
//  Module   : ov7670_sccb_init
//  Purpose  : Walks a constant table of OV7670 register writes. Each entry is
//             sent as one 3-phase SCCB write: DEV_ID, sub-address, data. The
//             sequence begins on an i_start pulse. There is a long settle
//             delay after the entry-0 soft reset and a short gap after every
//             other write.
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    QDIV     clocks per SCCB quarter-bit (4*QDIV clocks per bit), 1..65536
//    DEV_ID   SCCB write ID byte
//    RST_WAIT idle clocks after the soft-reset write (must be >= 1)
//    GAP      idle clocks between other consecutive writes (must be >= 1)
//  Ports
//    i_clk    system clock
//    i_rst_n  asynchronous, active-low reset
//    i_start  one-cycle pulse, accepted only when idle or done
//    o_busy   high while the register sequence is running
//    o_done   level, high after the last write until the next accepted start
//    o_sioc   SCCB clock (idles high)
//    io_siod  SCCB data, driven 0/1 or released (high-Z)
//    o_idx    table entry in progress
//  Build option
//    OV7670_COLORBAR_EN  appends two test-pattern writes (22 entries, not 20)
// ============================================================================
module ov7670_sccb_init #(
    parameter int         QDIV     = 125,
    parameter logic [7:0] DEV_ID   = 8'h42,
    parameter int         RST_WAIT = 50000,
    parameter int         GAP      = 4*QDIV
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_sioc,
    inout  wire        io_siod,
    output logic [5:0] o_idx
);

`ifdef OV7670_COLORBAR_EN
    localparam int c_NUM_ENTRIES = 22;
`else
    localparam int c_NUM_ENTRIES = 20;
`endif

    localparam logic [5:0]  c_LAST_IDX     = 6'(c_NUM_ENTRIES - 1);
    localparam logic [15:0] c_QMAX         = 16'(QDIV - 1);
    localparam logic [31:0] c_RST_WAIT_MAX = 32'(RST_WAIT - 1);
    localparam logic [31:0] c_GAP_MAX      = 32'(GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BYTE  = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4,
        ST_WAIT  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Register table: {sub-address, data}
    function automatic logic [15:0] f_table(input logic [5:0] idx);
        logic [15:0] v;
        case (idx)
            6'd0:    v = 16'h1280;   // COM7: soft reset
            6'd1:    v = 16'h1101;   // CLKRC: prescaler
            6'd2:    v = 16'h3A04;   // TSLB
            6'd3:    v = 16'h3DC0;   // COM13: gamma, UV saturation
            6'd4:    v = 16'h1713;   // HSTART
            6'd5:    v = 16'h1801;   // HSTOP
            6'd6:    v = 16'h32B6;   // HREF
            6'd7:    v = 16'h1902;   // VSTRT
            6'd8:    v = 16'h1A7A;   // VSTOP
            6'd9:    v = 16'h030A;   // VREF
            6'd10:   v = 16'h0C00;   // COM3
            6'd11:   v = 16'h3E00;   // COM14
            6'd12:   v = 16'h703A;   // SCALING_XSC
            6'd13:   v = 16'h7135;   // SCALING_YSC
            6'd14:   v = 16'h7211;   // SCALING_DCWCTR
            6'd15:   v = 16'h73F0;   // SCALING_PCLK_DIV
            6'd16:   v = 16'hA202;   // SCALING_PCLK_DELAY
            6'd17:   v = 16'h8C00;   // RGB444 off
            6'd18:   v = 16'h1204;   // COM7: RGB output
            6'd19:   v = 16'h40D0;   // COM15: RGB565, full range
`ifdef OV7670_COLORBAR_EN
            6'd20:   v = 16'h70BA;   // SCALING_XSC with test-pattern bit
            6'd21:   v = 16'h71B5;   // SCALING_YSC with test-pattern bit
`endif
            default: v = 16'hFFFF;
        endcase
        return v;
    endfunction

    state_t      r_state;
    logic [15:0] r_qcnt;      // clocks within the current quarter
    logic [1:0]  r_q;         // quarter within the current bit period
    logic [2:0]  r_bit;       // bit of the current byte, MSB first
    logic [1:0]  r_byte;      // 0 = ID, 1 = sub-address, 2 = data
    logic [31:0] r_wcnt;      // idle clocks spent in WAIT
    logic [5:0]  r_idx;
    logic        r_busy;
    logic        r_done;
    logic        r_sioc;
    logic        r_siod_oe;
    logic        r_siod_out;

    logic [15:0] w_entry;
    logic [7:0]  w_cur_byte;
    logic        w_cur_bit;
    logic        w_tick;
    logic        w_last_q;
    logic [31:0] w_wait_max;
    logic        w_sioc_nx;
    logic        w_oe_nx;
    logic        w_out_nx;

    assign w_entry  = f_table(r_idx);
    assign w_tick   = (r_qcnt == c_QMAX);
    assign w_last_q = (r_q == 2'd3);

    // The soft reset needs a long settle time before the next access.
    assign w_wait_max = (r_idx == 6'd0) ? c_RST_WAIT_MAX : c_GAP_MAX;

    always_comb begin
        w_cur_byte = DEV_ID;
        case (r_byte)
            2'd1:    w_cur_byte = w_entry[15:8];
            2'd2:    w_cur_byte = w_entry[7:0];
            default: w_cur_byte = DEV_ID;
        endcase
    end

    assign w_cur_bit = w_cur_byte[r_bit];

    // Bus levels for the quarter the FSM is in now. They are registered below,
    // so the pins follow the state by one clock. Every quarter keeps its full
    // QDIV length, and the pins never glitch.
    always_comb begin
        w_sioc_nx = 1'b1;
        w_oe_nx   = 1'b0;
        w_out_nx  = 1'b0;
        case (r_state)
            ST_START: begin
                // Data falls at q1 while the clock is high. The clock then
                // drops at q3.
                w_sioc_nx = (r_q != 2'd3);
                w_oe_nx   = (r_q != 2'd0);
            end
            ST_BYTE: begin
                w_sioc_nx = (r_q == 2'd1) || (r_q == 2'd2);
                w_oe_nx   = 1'b1;
                w_out_nx  = w_cur_bit;
            end
            ST_ACK: begin
                // Ninth bit: the line is released and the level is ignored.
                w_sioc_nx = (r_q == 2'd1) || (r_q == 2'd2);
            end
            ST_STOP: begin
                // Data is held low while the clock rises. It is released at q3.
                w_sioc_nx = (r_q != 2'd0);
                w_oe_nx   = (r_q != 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_qcnt     <= 16'd0;
            r_q        <= 2'd0;
            r_bit      <= 3'd0;
            r_byte     <= 2'd0;
            r_wcnt     <= 32'd0;
            r_idx      <= 6'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sioc     <= 1'b1;
            r_siod_oe  <= 1'b0;
            r_siod_out <= 1'b0;
        end else begin
            r_sioc     <= w_sioc_nx;
            r_siod_oe  <= w_oe_nx;
            r_siod_out <= w_out_nx;

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state <= ST_START;
                        r_idx   <= 6'd0;
                        r_q     <= 2'd0;
                        r_qcnt  <= 16'd0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end

                ST_START, ST_BYTE, ST_ACK, ST_STOP: begin
                    if (!w_tick) begin
                        r_qcnt <= r_qcnt + 16'd1;
                    end else begin
                        r_qcnt <= 16'd0;
                        r_q    <= r_q + 2'd1;   // wraps 3 -> 0 at bit end
                        if (w_last_q) begin
                            case (r_state)
                                ST_START: begin
                                    r_state <= ST_BYTE;
                                    r_byte  <= 2'd0;
                                    r_bit   <= 3'd7;
                                end
                                ST_BYTE: begin
                                    if (r_bit == 3'd0) begin
                                        r_state <= ST_ACK;
                                    end else begin
                                        r_bit <= r_bit - 3'd1;
                                    end
                                end
                                ST_ACK: begin
                                    if (r_byte == 2'd2) begin
                                        r_state <= ST_STOP;
                                    end else begin
                                        r_state <= ST_BYTE;
                                        r_byte  <= r_byte + 2'd1;
                                        r_bit   <= 3'd7;
                                    end
                                end
                                ST_STOP: begin
                                    r_state <= ST_WAIT;
                                    r_wcnt  <= 32'd0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                ST_WAIT: begin
                    if (r_wcnt == w_wait_max) begin
                        r_wcnt <= 32'd0;
                        if (r_idx == c_LAST_IDX) begin
                            // busy falls and done rises on the same edge
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + 6'd1;
                            r_state <= ST_START;
                            r_q     <= 2'd0;
                            r_qcnt  <= 16'd0;
                        end
                    end else begin
                        r_wcnt <= r_wcnt + 32'd1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_siod = r_siod_oe ? r_siod_out : 1'bz;
    assign o_sioc  = r_sioc;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_idx   = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_sccb_init.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ov7670_sccb_init
//  Purpose  : Self-checking bench for ov7670_sccb_init. A bus decoder rebuilds
//             each SCCB write from the pins. The decoder finds START and STOP
//             from data edges while the clock is high, and takes bits on
//             clock rises. The decoded writes are compared with what the
//             register sequence should produce.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_ov7670_sccb_init;
    localparam int         QDIV     = 2;
    localparam int         RST_WAIT = 10;
    localparam int         GAP      = 8;
    localparam logic [7:0] DEV_ID   = 8'h42;
`ifdef OV7670_COLORBAR_EN
    localparam int N_ENT = 22;
`else
    localparam int N_ENT = 20;
`endif
    // A write is 29 bit periods of 4 quarters (232 clocks). The START data
    // edge comes one quarter in, and the STOP edge one quarter before the end.
    localparam int SPAN   = 29*4*QDIV - 2*QDIV;
    // 27 data/ACK clock pulses, plus the clock rise inside STOP.
    localparam int NRISE  = 28;
    // Released line reads 1 through the pull-up.
    localparam logic [26:0] ID_ACK_MASK = {8'hFF, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1};

    logic       i_clk   = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       o_busy;
    logic       o_done;
    logic       o_sioc;
    logic [5:0] o_idx;
    wire        io_siod;

    pullup (io_siod);

    always #5 i_clk = ~i_clk;

    ov7670_sccb_init #(
        .QDIV     (QDIV),
        .DEV_ID   (DEV_ID),
        .RST_WAIT (RST_WAIT),
        .GAP      (GAP)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_sioc  (o_sioc),
        .io_siod (io_siod),
        .o_idx   (o_idx)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- bus decoder ----------------
    int           cyc         = 0;
    logic         p_sioc      = 1'b1;
    logic         p_siod      = 1'b1;
    logic         in_frame    = 1'b0;
    logic [27:0]  shreg       = '0;
    int           nbits       = 0;
    int           t_start     = 0;
    int           t_stop_last = -1;
    int           cur_gap     = -1;
    int           cur_idx     = 0;
    int           n_starts    = 0;
    int           sioc_lows   = 0;
    logic [26:0]  fr_bits[$];
    int           fr_nbits[$];
    int           fr_span[$];
    int           fr_gap[$];
    int           fr_idx_start[$];
    int           fr_idx_stop[$];
    logic [26:0]  run_a[$];

    initial begin
        logic siod_v;
        forever begin
            @(negedge i_clk);
            cyc++;
            siod_v = io_siod;
            if (!i_rst_n) begin
                in_frame = 1'b0;
            end else begin
                if (!o_sioc) sioc_lows++;
                if (o_sioc && p_sioc && p_siod && !siod_v) begin
                    n_starts++;
                    in_frame = 1'b1;
                    nbits    = 0;
                    shreg    = '0;
                    t_start  = cyc;
                    cur_gap  = (t_stop_last < 0) ? -1 : cyc - t_stop_last;
                    cur_idx  = int'(o_idx);
                end else if (o_sioc && p_sioc && !p_siod && siod_v) begin
                    if (in_frame) begin
                        fr_bits.push_back(shreg[27:1]);
                        fr_nbits.push_back(nbits);
                        fr_span.push_back(cyc - t_start);
                        fr_gap.push_back(cur_gap);
                        fr_idx_start.push_back(cur_idx);
                        fr_idx_stop.push_back(int'(o_idx));
                    end
                    in_frame    = 1'b0;
                    t_stop_last = cyc;
                end else if (o_sioc && !p_sioc && in_frame) begin
                    shreg = {shreg[26:0], siod_v};
                    nbits++;
                end
            end
            p_sioc = o_sioc;
            p_siod = siod_v;
        end
    end

    task automatic clear_mon();
        fr_bits.delete();
        fr_nbits.delete();
        fr_span.delete();
        fr_gap.delete();
        fr_idx_start.delete();
        fr_idx_stop.delete();
        n_starts    = 0;
        sioc_lows   = 0;
        t_stop_last = -1;
    endtask

    // Register values whose content is fixed. Other entries are checked for
    // framing, ID and ACK only.
    function automatic bit known_entry(input int k, output logic [15:0] v);
        v = 16'h0000;
        if (k == 0)  begin v = 16'h1280; return 1'b1; end
        if (k == 18) begin v = 16'h1204; return 1'b1; end
        if (k == 19) begin v = 16'h40D0; return 1'b1; end
`ifdef OV7670_COLORBAR_EN
        if (k == 20) begin v = 16'h70BA; return 1'b1; end
        if (k == 21) begin v = 16'h71B5; return 1'b1; end
`endif
        return 1'b0;
    endfunction

    function automatic logic [26:0] frame_of(input logic [15:0] e);
        return {DEV_ID, 1'b1, e[15:8], 1'b1, e[7:0], 1'b1};
    endfunction

    task automatic pulse_start();
        @(posedge i_clk); #1;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge i_clk); #1;
            if (fr_bits.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge i_clk); #1;
            if (o_done) begin ok = 1'b1; break; end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        i_rst_n = 1'b0;
        i_start = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        checks++; if (o_sioc !== 1'b1) begin failures++; $display("FAIL reset_sioc: got %b expected 1", o_sioc); end
        checks++; if (io_siod !== 1'b1) begin failures++; $display("FAIL reset_siod: got %b expected released(1)", io_siod); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", o_done); end
        checks++; if (o_idx !== 6'd0) begin failures++; $display("FAIL reset_idx: got %0d expected 0", o_idx); end
        i_rst_n = 1'b1;
        clear_mon();
        repeat (30) @(posedge i_clk);
        #1;
        checks++; if (n_starts != 0 || sioc_lows != 0 || o_busy !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset: starts=%0d lows=%0d busy=%b expected 0/0/0", n_starts, sioc_lows, o_busy);
        end
    endtask

    task automatic test_first_write();
        bit ok;
        clear_mon();
        repeat ($urandom_range(1, 20)) @(posedge i_clk);
        pulse_start();
        checks++; if (o_busy !== 1'b1 || o_done !== 1'b0) begin
            failures++; $display("FAIL start_accept: busy=%b done=%b expected 1/0", o_busy, o_done);
        end
        wait_frames(1, 2000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL first_write_timeout: got %0d frames expected 1", fr_bits.size()); end
        if (ok) begin
            checks++; if (fr_nbits[0] != NRISE) begin failures++; $display("FAIL first_nbits: got %0d expected %0d", fr_nbits[0], NRISE); end
            checks++; if (fr_bits[0] !== frame_of(16'h1280)) begin
                failures++; $display("FAIL first_bits: got %07h expected %07h", fr_bits[0], frame_of(16'h1280));
            end
            checks++; if (fr_span[0] != SPAN) begin failures++; $display("FAIL first_span: got %0d expected %0d", fr_span[0], SPAN); end
            checks++; if (fr_idx_start[0] != 0 || fr_idx_stop[0] != 0) begin
                failures++; $display("FAIL first_idx: got %0d/%0d expected 0/0", fr_idx_start[0], fr_idx_stop[0]);
            end
        end
        wait_frames(2, 2000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL second_write_timeout: got %0d frames expected 2", fr_bits.size()); end
        if (ok) begin
            checks++; if (fr_gap[1] != RST_WAIT + 2*QDIV) begin
                failures++; $display("FAIL reset_wait_gap: got %0d expected %0d", fr_gap[1], RST_WAIT + 2*QDIV);
            end
            checks++; if (fr_idx_start[1] != 1) begin failures++; $display("FAIL second_idx: got %0d expected 1", fr_idx_start[1]); end
        end
    endtask

    task automatic test_full_run();
        bit          ok;
        bit          both;
        logic        prev_busy;
        int          lows_at_done;
        logic [15:0] v;
        both      = 1'b0;
        prev_busy = o_busy;
        ok        = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge i_clk); #1;
            if (o_done && o_busy) both = 1'b1;
            if (o_done) begin ok = 1'b1; break; end
            prev_busy = o_busy;
        end
        checks++; if (!ok) begin failures++; $display("FAIL done_timeout: done=%b expected 1", o_done); end
        checks++; if (prev_busy !== 1'b1 || o_busy !== 1'b0 || both) begin
            failures++; $display("FAIL done_busy_edge: busy_before=%b busy_now=%b overlap=%b expected 1/0/0", prev_busy, o_busy, both);
        end
        lows_at_done = sioc_lows;
        repeat (60) @(posedge i_clk);
        #1;
        checks++; if (fr_bits.size() != N_ENT || n_starts != N_ENT) begin
            failures++; $display("FAIL write_count: got %0d stops %0d starts expected %0d", fr_bits.size(), n_starts, N_ENT);
        end
        checks++; if (o_sioc !== 1'b1 || io_siod !== 1'b1 || sioc_lows != lows_at_done) begin
            failures++; $display("FAIL bus_idle_after_done: sioc=%b siod=%b extra_lows=%0d expected 1/1/0", o_sioc, io_siod, sioc_lows - lows_at_done);
        end
        checks++; if (o_idx !== 6'(N_ENT - 1) || o_done !== 1'b1) begin
            failures++; $display("FAIL final_idx: got %0d done=%b expected %0d/1", o_idx, o_done, N_ENT - 1);
        end
        for (int k = 0; k < fr_bits.size(); k++) begin
            checks++; if (fr_nbits[k] != NRISE || fr_span[k] != SPAN || fr_idx_start[k] != k) begin
                failures++; $display("FAIL write_shape[%0d]: rises=%0d span=%0d idx=%0d expected %0d/%0d/%0d",
                                     k, fr_nbits[k], fr_span[k], fr_idx_start[k], NRISE, SPAN, k);
            end
            if (k > 0) begin
                checks++; if (fr_gap[k] != ((k == 1) ? RST_WAIT : GAP) + 2*QDIV) begin
                    failures++; $display("FAIL gap[%0d]: got %0d expected %0d", k, fr_gap[k], ((k == 1) ? RST_WAIT : GAP) + 2*QDIV);
                end
            end
            if (known_entry(k, v)) begin
                checks++; if (fr_bits[k] !== frame_of(v)) begin
                    failures++; $display("FAIL entry[%0d]: got %07h expected %07h", k, fr_bits[k], frame_of(v));
                end
            end else begin
                checks++; if ((fr_bits[k] & ID_ACK_MASK) !== (frame_of(16'h0000) & ID_ACK_MASK)) begin
                    failures++; $display("FAIL id_ack[%0d]: got %07h expected id/ack %07h", k,
                                         fr_bits[k] & ID_ACK_MASK, frame_of(16'h0000) & ID_ACK_MASK);
                end
            end
        end
        run_a = fr_bits;
    endtask

    task automatic test_ignore_start();
        bit ok;
        clear_mon();
        pulse_start();
        checks++; if (o_busy !== 1'b1 || o_done !== 1'b0) begin
            failures++; $display("FAIL restart_from_done: busy=%b done=%b expected 1/0", o_busy, o_done);
        end
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge i_clk); #1;
            if (o_idx == 6'd5) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin failures++; $display("FAIL reach_entry5: got idx %0d expected 5", o_idx); end
        repeat ($urandom_range(0, 150)) @(posedge i_clk);
        pulse_start();
        checks++; if (o_idx !== 6'd5 || o_busy !== 1'b1) begin
            failures++; $display("FAIL ignore_start_1: idx=%0d busy=%b expected 5/1", o_idx, o_busy);
        end
        repeat ($urandom_range(0, 40)) @(posedge i_clk);
        pulse_start();
        checks++; if (o_idx !== 6'd5 || o_busy !== 1'b1) begin
            failures++; $display("FAIL ignore_start_2: idx=%0d busy=%b expected 5/1", o_idx, o_busy);
        end
        wait_done(20000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ignore_done_timeout: done=%b expected 1", o_done); end
        repeat (10) @(posedge i_clk);
        #1;
        checks++; if (fr_bits.size() != N_ENT || n_starts != N_ENT) begin
            failures++; $display("FAIL ignore_count: got %0d/%0d expected %0d", fr_bits.size(), n_starts, N_ENT);
        end
        for (int k = 0; k < fr_bits.size() && k < run_a.size(); k++) begin
            checks++; if (fr_bits[k] !== run_a[k] || fr_idx_start[k] != k) begin
                failures++; $display("FAIL ignore_seq[%0d]: got %07h idx %0d expected %07h idx %0d", k, fr_bits[k], fr_idx_start[k], run_a[k], k);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int target;
        clear_mon();
        pulse_start();
        // Clock rises 19..26 carry the data byte. Stop somewhere inside it.
        target = 19 + $urandom_range(0, 6);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge i_clk); #1;
            if (o_idx == 6'd3 && in_frame && nbits == target) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin failures++; $display("FAIL reach_entry3_data: idx=%0d rises=%0d expected 3/%0d", o_idx, nbits, target); end
        repeat ($urandom_range(0, 3)) @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_sioc !== 1'b1 || io_siod !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_idx !== 6'd0) begin
            failures++; $display("FAIL async_reset: sioc=%b siod=%b busy=%b done=%b idx=%0d expected 1/1/0/0/0",
                                 o_sioc, io_siod, o_busy, o_done, o_idx);
        end
        repeat ($urandom_range(1, 5)) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        clear_mon();
        repeat (600) @(posedge i_clk);
        #1;
        checks++; if (n_starts != 0 || sioc_lows != 0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            failures++; $display("FAIL no_resume: starts=%0d lows=%0d busy=%b done=%b expected 0/0/0/0", n_starts, sioc_lows, o_busy, o_done);
        end
        pulse_start();
        wait_frames(1, 2000, ok);
        checks++; if (!ok || fr_bits[0] !== frame_of(16'h1280) || fr_idx_start[0] != 0) begin
            failures++; $display("FAIL restart_entry0: got %07h expected %07h", ok ? fr_bits[0] : 27'h0, frame_of(16'h1280));
        end
        wait_done(20000, ok);
        repeat (10) @(posedge i_clk);
        #1;
        checks++; if (!ok || fr_bits.size() != N_ENT) begin
            failures++; $display("FAIL restart_count: got %0d writes done=%b expected %0d/1", fr_bits.size(), o_done, N_ENT);
        end
    endtask

    initial begin
        test_reset();
        test_first_write();
        test_full_run();
        test_ignore_start();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
